// File: rtl/dft_gen_pkg.sv
// -----------------------------------------------------------------------------
// dft_gen_pkg
// Shared types and constants for the DFT frame stimulus generator.
//   pattern_e   : data pattern selector (matches the 2-bit cfg_mode encoding)
//   gen_state_e : generator FSM states
//   LFSR_POLY   : feedback taps of x^32+x^22+x^2+x+1 (x^32 term is the MSB
//                 shifted out; remaining terms are bits 22, 2, 1 and 0)
//   lfsr_step   : one left-shifting Galois step of that polynomial
// -----------------------------------------------------------------------------
package dft_gen_pkg;

    typedef enum logic [1:0] {
        PAT_RAMP    = 2'd0,
        PAT_IMPULSE = 2'd1,
        PAT_ALT     = 2'd2,
        PAT_LFSR    = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } gen_state_e;

    localparam logic [31:0] LFSR_POLY = 32'h0040_0007;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/dft_gen_lfsr32.sv
// -----------------------------------------------------------------------------
// dft_gen_lfsr32
// 32-bit Galois LFSR that advances one step per cycle in which adv_i is high.
// Ports:
//   clk      in  clock
//   rst_n    in  synchronous active-low reset, loads SEED
//   adv_i    in  advance one step at the next edge
//   state_o  out current LFSR state
// -----------------------------------------------------------------------------
module dft_gen_lfsr32
    import dft_gen_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else if (adv_i) begin
            state_q <= lfsr_step(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/dft_frame_gen.sv
// -----------------------------------------------------------------------------
// dft_frame_gen
// Frame stimulus source for the mixed-radix DFT sink. Emits frames of a
// runtime-selected point count separated by a programmable idle gap, with
// valid/ready handshake, sop/eop framing and per-frame size/inverse sideband.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start, stop      one-cycle run control pulses
//   cfg_*            run configuration, captured when a run starts
//   src_valid/ready  downstream handshake
//   src_sop/eop      frame delimiters
//   src_real/imag    sample data
//   src_dftpts       point count of the current frame
//   src_inverse      inverse-DFT flag of the current frame
//   busy             high outside IDLE
//   frame_cnt        frames completed in this run (wraps)
//   cfg_err          one-cycle pulse when start is rejected (cfg_dftpts==0)
// -----------------------------------------------------------------------------
module dft_frame_gen
    import dft_gen_pkg::*;
#(
    parameter int          DW        = 18,
    parameter int          PTS_W     = 12,
    parameter int          GAP_W     = 16,
    parameter int          NFR_W     = 8,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [PTS_W-1:0] cfg_dftpts,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [NFR_W-1:0] cfg_nframes,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_inverse,
    output logic             src_valid,
    input  logic             src_ready,
    output logic             src_sop,
    output logic             src_eop,
    output logic [DW-1:0]    src_real,
    output logic [DW-1:0]    src_imag,
    output logic [PTS_W-1:0] src_dftpts,
    output logic             src_inverse,
    output logic             busy,
    output logic [NFR_W-1:0] frame_cnt,
    output logic             cfg_err
);

    localparam logic signed [DW-1:0] AMP  = DW'(1 << (DW - 2));
    localparam logic signed [DW-1:0] NAMP = -AMP;

    function automatic logic [DW-1:0] pat_re(input pattern_e m, input logic [PTS_W-1:0] k,
                                             input logic [31:0] l);
        logic [DW-1:0] r;
        case (m)
            PAT_RAMP:    r = DW'(k);
            PAT_IMPULSE: r = (k == '0) ? AMP : '0;
            PAT_ALT:     r = k[0] ? NAMP : AMP;
            default:     r = l[DW-1:0];
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] pat_im(input pattern_e m, input logic [PTS_W-1:0] k,
                                             input logic [31:0] l);
        logic [DW-1:0] r;
        case (m)
            PAT_RAMP: r = DW'(k);
            PAT_LFSR: r = l[31:32-DW];
            default:  r = '0;
        endcase
        return r;
    endfunction

    gen_state_e       state_q, state_d;
    logic [PTS_W-1:0] k_q, k_d, pts_q, pts_d, dftpts_q, dftpts_d;
    pattern_e         mode_q, mode_d;
    logic             inv_q, inv_d, inverse_q, inverse_d;
    logic [GAP_W-1:0] gap_cfg_q, gap_cfg_d, gap_cnt_q, gap_cnt_d;
    logic [NFR_W-1:0] nfr_q, nfr_d, frame_cnt_q, frame_cnt_d;
    logic             stop_pend_q, stop_pend_d;
    logic             valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, cfg_err_q, cfg_err_d;
    logic [DW-1:0]    re_q, re_d, im_q, im_d;

    logic             xfer, stop_any, last_frame, load, frame_start;
    logic [PTS_W-1:0] ld_k, ld_pts;
    pattern_e         ld_mode;
    logic             ld_inv;
    logic [31:0]      lfsr_state, lfsr_nxt;

    assign xfer       = valid_q && src_ready;
    assign stop_any   = stop_pend_q || stop;
    assign last_frame = (nfr_q != '0) && ((frame_cnt_q + NFR_W'(1)) == nfr_q);

    dft_gen_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (xfer),
        .state_o (lfsr_state)
    );

    // A beat loaded in the same cycle as a transfer must see the post-advance state.
    assign lfsr_nxt = xfer ? lfsr_step(lfsr_state) : lfsr_state;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        pts_d       = pts_q;
        mode_d      = mode_q;
        inv_d       = inv_q;
        gap_cfg_d   = gap_cfg_q;
        gap_cnt_d   = gap_cnt_q;
        nfr_d       = nfr_q;
        frame_cnt_d = frame_cnt_q;
        stop_pend_d = stop_pend_q;
        valid_d     = valid_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        re_d        = re_q;
        im_d        = im_q;
        dftpts_d    = dftpts_q;
        inverse_d   = inverse_q;
        cfg_err_d   = 1'b0;
        load        = 1'b0;
        frame_start = 1'b0;
        ld_k        = '0;
        ld_pts      = pts_q;
        ld_mode     = mode_q;
        ld_inv      = inv_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_dftpts == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        pts_d       = cfg_dftpts;
                        mode_d      = pattern_e'(cfg_mode);
                        inv_d       = cfg_inverse;
                        gap_cfg_d   = cfg_gap;
                        nfr_d       = cfg_nframes;
                        frame_cnt_d = '0;
                        stop_pend_d = 1'b0;
                        frame_start = 1'b1;
                        // Shadows are being written this edge, so take beat 0 from cfg directly.
                        ld_pts      = cfg_dftpts;
                        ld_mode     = pattern_e'(cfg_mode);
                        ld_inv      = cfg_inverse;
                    end
                end
            end
            SEND: begin
                if (stop) stop_pend_d = 1'b1;
                if (xfer) begin
                    if (eop_q) begin
                        frame_cnt_d = frame_cnt_q + NFR_W'(1);
                        if (last_frame || stop_any) begin
                            state_d     = IDLE;
                            stop_pend_d = 1'b0;
                            valid_d     = 1'b0;
                            sop_d       = 1'b0;
                            eop_d       = 1'b0;
                        end else if (gap_cfg_q == '0) begin
                            frame_start = 1'b1;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = gap_cfg_q;
                            valid_d   = 1'b0;
                            sop_d     = 1'b0;
                            eop_d     = 1'b0;
                        end
                    end else begin
                        load = 1'b1;
                        ld_k = k_q + PTS_W'(1);
                    end
                end
            end
            GAP: begin
                if (stop_any) begin
                    state_d     = IDLE;
                    stop_pend_d = 1'b0;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    frame_start = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_start) begin
            state_d = SEND;
            load    = 1'b1;
            ld_k    = '0;
        end

        if (load) begin
            k_d       = ld_k;
            valid_d   = 1'b1;
            sop_d     = (ld_k == '0);
            eop_d     = (ld_k == (ld_pts - PTS_W'(1)));
            re_d      = pat_re(ld_mode, ld_k, lfsr_nxt);
            im_d      = pat_im(ld_mode, ld_k, lfsr_nxt);
            dftpts_d  = ld_pts;
            inverse_d = ld_inv;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            pts_q       <= '0;
            mode_q      <= PAT_RAMP;
            inv_q       <= 1'b0;
            gap_cfg_q   <= '0;
            gap_cnt_q   <= '0;
            nfr_q       <= '0;
            frame_cnt_q <= '0;
            stop_pend_q <= 1'b0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            re_q        <= '0;
            im_q        <= '0;
            dftpts_q    <= '0;
            inverse_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            pts_q       <= pts_d;
            mode_q      <= mode_d;
            inv_q       <= inv_d;
            gap_cfg_q   <= gap_cfg_d;
            gap_cnt_q   <= gap_cnt_d;
            nfr_q       <= nfr_d;
            frame_cnt_q <= frame_cnt_d;
            stop_pend_q <= stop_pend_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            re_q        <= re_d;
            im_q        <= im_d;
            dftpts_q    <= dftpts_d;
            inverse_q   <= inverse_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign src_valid   = valid_q;
    assign src_sop     = sop_q;
    assign src_eop     = eop_q;
    assign src_real    = re_q;
    assign src_imag    = im_q;
    assign src_dftpts  = dftpts_q;
    assign src_inverse = inverse_q;
    assign busy        = (state_q != IDLE);
    assign frame_cnt   = frame_cnt_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_dft_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_dft_frame_gen
// Directed bench for dft_frame_gen: a table of per-beat pattern vectors plus
// hand-written multi-cycle sequences (long frames with gap, back-to-back
// frames, backpressure, stop, rejected start, reset mid-frame).
// -----------------------------------------------------------------------------
module tb_dft_frame_gen;

    localparam int          DW    = 18;
    localparam int          PTS_W = 12;
    localparam int          GAP_W = 16;
    localparam int          NFR_W = 8;
    localparam logic [31:0] SEED  = 32'hACE1_2468;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [PTS_W-1:0] cfg_dftpts = '0;
    logic [GAP_W-1:0] cfg_gap = '0;
    logic [NFR_W-1:0] cfg_nframes = '0;
    logic [1:0]       cfg_mode = '0;
    logic             cfg_inverse = 1'b0;
    logic             src_valid;
    logic             src_ready = 1'b1;
    logic             src_sop, src_eop;
    logic [DW-1:0]    src_real, src_imag;
    logic [PTS_W-1:0] src_dftpts;
    logic             src_inverse, busy, cfg_err;
    logic [NFR_W-1:0] frame_cnt;

    dft_frame_gen #(
        .DW(DW), .PTS_W(PTS_W), .GAP_W(GAP_W), .NFR_W(NFR_W), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_dftpts(cfg_dftpts), .cfg_gap(cfg_gap), .cfg_nframes(cfg_nframes),
        .cfg_mode(cfg_mode), .cfg_inverse(cfg_inverse),
        .src_valid(src_valid), .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop),
        .src_real(src_real), .src_imag(src_imag), .src_dftpts(src_dftpts),
        .src_inverse(src_inverse), .busy(busy), .frame_cnt(frame_cnt), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent bitwise form of x^32+x^22+x^2+x+1 (Galois, left-shifting).
    function automatic logic [31:0] lfsr_model(input logic [31:0] s);
        logic [31:0] n;
        logic        fb;
        fb = s[31];
        for (int i = 31; i > 0; i--) n[i] = s[i-1];
        n[0]  = fb;
        n[1]  = n[1] ^ fb;
        n[2]  = n[2] ^ fb;
        n[22] = n[22] ^ fb;
        return n;
    endfunction

    function automatic logic [61:0] all_outs();
        return {src_valid, src_sop, src_eop, src_real, src_imag, src_dftpts,
                src_inverse, busy, frame_cnt, cfg_err};
    endfunction

    task automatic start_run(input logic [PTS_W-1:0] pts, input logic [GAP_W-1:0] gap,
                             input logic [NFR_W-1:0] nfr, input logic [1:0] mode,
                             input logic inv);
        cfg_dftpts  = pts;
        cfg_gap     = gap;
        cfg_nframes = nfr;
        cfg_mode    = mode;
        cfg_inverse = inv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Frame monitor; cycle 1 is the first negedge after start was sampled.
    int m_sop_cnt, m_eop_cnt, m_first_sop, m_last_sop, m_first_eop, m_last_eop;
    int m_nvalid, m_fall;
    logic [DW-1:0] m_eop_real;

    task automatic run_monitor(input int maxcyc);
        m_sop_cnt = 0; m_eop_cnt = 0; m_first_sop = -1; m_last_sop = -1;
        m_first_eop = -1; m_last_eop = -1; m_nvalid = 0; m_fall = -1; m_eop_real = '0;
        for (int c = 1; c <= maxcyc; c++) begin
            if (src_valid && src_ready) begin
                m_nvalid++;
                if (src_sop) begin
                    if (m_sop_cnt == 0) m_first_sop = c;
                    m_last_sop = c;
                    m_sop_cnt++;
                end
                if (src_eop) begin
                    if (m_eop_cnt == 0) begin
                        m_first_eop = c;
                        m_eop_real  = src_real;
                    end
                    m_last_eop = c;
                    m_eop_cnt++;
                end
            end
            if (!busy) begin
                m_fall = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [1:0]    mode;
        int            k;
        logic          sop;
        logic          eop;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } vec_t;

    vec_t vt[16];

    initial begin
        logic [31:0] ls;
        logic [3:0]  rdy_pat;
        logic [DW+2:0] held;
        int  exp_k, bad_seq, bad_hold;
        logic stalled;

        // ---- vector table: 4-point frames, LFSR first so it starts at the seed
        ls = SEED;
        for (int k = 0; k < 4; k++) begin
            vt[k]      = '{2'd3, k, k == 0, k == 3, ls[17:0], ls[31:14]};
            ls         = lfsr_model(ls);
            vt[4 + k]  = '{2'd0, k, k == 0, k == 3, 18'(k), 18'(k)};
            vt[8 + k]  = '{2'd1, k, k == 0, k == 3, (k == 0) ? 18'h10000 : 18'h0, 18'h0};
            vt[12 + k] = '{2'd2, k, k == 0, k == 3, (k % 2 == 0) ? 18'h10000 : 18'h30000, 18'h0};
        end

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outputs", 64'(all_outs()), 64'h0);

        for (int i = 0; i < 16; i++) begin
            if (vt[i].k == 0) begin
                if (i > 0) @(negedge clk);
                start_run(12'd4, 16'd0, 8'd1, vt[i].mode, 1'b0);
            end else begin
                @(negedge clk);
            end
            check($sformatf("vec%0d_m%0d_k%0d", i, vt[i].mode, vt[i].k),
                  64'({src_valid, src_sop, src_eop, src_real, src_imag}),
                  64'({1'b1, vt[i].sop, vt[i].eop, vt[i].re, vt[i].im}));
        end
        @(negedge clk);
        check("vec_end_idle", 64'({busy, src_valid, frame_cnt}), 64'({1'b0, 1'b0, 8'd1}));

        // ---- single-point frame: sop and eop together, sideband latched
        start_run(12'd1, 16'd0, 8'd1, 2'd0, 1'b1);
        check("n1_beat", 64'({src_valid, src_sop, src_eop, src_dftpts, src_inverse}),
              64'({1'b1, 1'b1, 1'b1, 12'd1, 1'b1}));
        @(negedge clk);
        check("n1_done", 64'({busy, src_valid, frame_cnt}), 64'({1'b0, 1'b0, 8'd1}));

        // ---- 1200 points, gap 1000, two frames
        start_run(12'd1200, 16'd1000, 8'd2, 2'd0, 1'b0);
        run_monitor(4000);
        check("long_first_sop", 64'(m_first_sop), 64'd1);
        check("long_first_eop", 64'(m_first_eop), 64'd1200);
        check("long_eop_real", 64'(m_eop_real), 64'd1199);
        check("long_second_sop", 64'(m_last_sop), 64'd2201);
        check("long_second_eop", 64'(m_last_eop), 64'd3400);
        check("long_nvalid", 64'(m_nvalid), 64'd2400);
        check("long_busy_fall", 64'(m_fall), 64'd3401);
        check("long_frame_cnt", 64'(frame_cnt), 64'd2);

        // ---- 16 points, gap 0, three frames back-to-back
        @(negedge clk);
        start_run(12'd16, 16'd0, 8'd3, 2'd0, 1'b0);
        run_monitor(200);
        check("b2b_sops", 64'({m_sop_cnt, m_last_sop}), 64'({32'd3, 32'd33}));
        check("b2b_eops", 64'({m_eop_cnt, m_last_eop}), 64'({32'd3, 32'd48}));
        check("b2b_nvalid", 64'(m_nvalid), 64'd48);
        check("b2b_busy_fall", 64'(m_fall), 64'd49);
        check("b2b_frame_cnt", 64'(frame_cnt), 64'd3);

        // ---- backpressure: ready 1,0,0,1 repeating
        @(negedge clk);
        rdy_pat = 4'b1001;
        start_run(12'd8, 16'd0, 8'd1, 2'd0, 1'b0);
        exp_k = 0; bad_seq = 0; bad_hold = 0; stalled = 1'b0; held = '0;
        for (int c = 0; c < 100 && busy; c++) begin
            if (stalled && ({src_valid, src_sop, src_eop, src_real} !== held)) bad_hold++;
            src_ready = rdy_pat[c % 4];
            if (src_valid && src_ready) begin
                if (src_real != 18'(exp_k) || src_sop != (exp_k == 0) || src_eop != (exp_k == 7))
                    bad_seq++;
                exp_k++;
            end
            stalled = src_valid && !src_ready;
            held    = {src_valid, src_sop, src_eop, src_real};
            @(negedge clk);
        end
        src_ready = 1'b1;
        check("bp_hold_violations", 64'(bad_hold), 64'd0);
        check("bp_seq_errors", 64'(bad_seq), 64'd0);
        check("bp_beats", 64'(exp_k), 64'd8);
        check("bp_idle", 64'(busy), 64'd0);

        // ---- continuous mode, stop pulsed while k=1 is presented
        @(negedge clk);
        start_run(12'd4, 16'd3, 8'd0, 2'd0, 1'b0);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        run_monitor(50);
        check("stop_eop", 64'({m_eop_cnt, m_first_eop}), 64'({32'd1, 32'd2}));
        check("stop_eop_real", 64'(m_eop_real), 64'd3);
        check("stop_no_sop", 64'(m_sop_cnt), 64'd0);
        check("stop_fall", 64'(m_fall), 64'd3);
        check("stop_frame_cnt", 64'(frame_cnt), 64'd1);

        // ---- stop during the gap ends the run immediately
        @(negedge clk);
        start_run(12'd2, 16'd5, 8'd0, 2'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("gapstop_in_gap", 64'({busy, src_valid}), 64'({1'b1, 1'b0}));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("gapstop_idle", 64'({busy, src_valid}), 64'({1'b0, 1'b0}));

        // ---- rejected start
        @(negedge clk);
        start_run(12'd0, 16'd0, 8'd1, 2'd0, 1'b0);
        check("err_pulse", 64'({cfg_err, busy}), 64'({1'b1, 1'b0}));
        @(negedge clk);
        check("err_clear", 64'({cfg_err, busy, src_valid}), 64'h0);

        // ---- reset at k=5 of an LFSR frame
        start_run(12'd8, 16'd0, 8'd0, 2'd3, 1'b1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", 64'(all_outs()), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(12'd2, 16'd0, 8'd1, 2'd3, 1'b0);
        check("rst_lfsr_seed", 64'({src_real, src_imag}), 64'({SEED[17:0], SEED[31:14]}));

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
